// File: rtl/lcrc_feed_sequencer.sv
// DLL TX sequencer feeding the bit-serial LCRC engine: collects a 1/2-beat TLP,
// stamps it with the next transmit sequence number and returns {seq, crc} with a done pulse.
module lcrc_feed_sequencer #(
    parameter int                 DATA_W   = 128,
    parameter int                 SEQ_W    = 12,
    parameter logic [SEQ_W-1:0]   SEQ_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tlp_data_i,
    input  logic              tlp_valid_i,
    input  logic              tlp_last_i,
    output logic              tlp_ready_o,
    input  logic              rb_full_i,
    output logic [1:0]        lcrc_ctrl_o,
    output logic              lcrc_start_o,
    output logic [DATA_W-1:0] lcrc_data_o,
    output logic              lcrc_end_o,
    output logic              lcrc_skip_o,
    input  logic [31:0]       lcrc_in_i,
    input  logic              lcrc_vld_i,
    output logic              done_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [31:0]       crc_o,
    output logic              tlp_err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {IDLE, COLLECT, SEQ, B0, B1, CRC} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  beat0_q, beat1_q;
    logic               last0_q;
    logic [SEQ_W-1:0]   next_seq_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [31:0]        crc_q;
    logic               done_q, err_q;

    logic               ready_d, capture0, capture1, err_d, finish;

    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        capture0     = 1'b0;
        capture1     = 1'b0;
        err_d        = 1'b0;
        finish       = 1'b0;
        lcrc_ctrl_o  = 2'b00;
        lcrc_start_o = 1'b0;
        lcrc_data_o  = '0;
        lcrc_end_o   = 1'b0;
        lcrc_skip_o  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = !rb_full_i;
                if (tlp_valid_i && !rb_full_i) begin
                    capture0 = 1'b1;
                    state_d  = tlp_last_i ? SEQ : COLLECT;
                end
            end
            // Once beat0 is in, the TLP must complete regardless of replay-buffer pressure.
            COLLECT: begin
                ready_d = 1'b1;
                if (tlp_valid_i) begin
                    capture1 = 1'b1;
                    err_d    = !tlp_last_i;
                    state_d  = SEQ;
                end
            end
            SEQ: begin
                lcrc_start_o              = 1'b1;
                lcrc_data_o[SEQ_W-1:0]    = next_seq_q;
                state_d                   = B0;
            end
            B0: begin
                lcrc_ctrl_o = 2'b01;
                lcrc_data_o = beat0_q;
                lcrc_end_o  = last0_q;
                state_d     = last0_q ? CRC : B1;
            end
            B1: begin
                lcrc_ctrl_o = 2'b10;
                lcrc_data_o = beat1_q;
                state_d     = CRC;
            end
            CRC: begin
                lcrc_ctrl_o = 2'b11;
                lcrc_skip_o = last0_q;
                if (lcrc_vld_i) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat0_q    <= '0;
            beat1_q    <= '0;
            last0_q    <= 1'b0;
            next_seq_q <= SEQ_INIT;
            seq_q      <= '0;
            crc_q      <= 32'hFFFF_FFFF;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            err_q   <= err_d;
            if (capture0) begin
                beat0_q <= tlp_data_i;
                last0_q <= tlp_last_i;
            end
            if (capture1) begin
                beat1_q <= tlp_data_i;
            end
            if (finish) begin
                crc_q      <= lcrc_in_i;
                seq_q      <= next_seq_q;
                next_seq_q <= next_seq_q + SEQ_W'(1);
            end
        end
    end

    // Ready is forced low while reset is held even though the state already reads IDLE.
    assign tlp_ready_o = ready_d & rst_n;
    assign done_o      = done_q;
    assign seq_o       = seq_q;
    assign crc_o       = crc_q;
    assign tlp_err_o   = err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_lcrc_feed_sequencer.sv
// Directed bench for lcrc_feed_sequencer: a behavioural LCRC engine answers the
// DUT's ctrl sequence; table vectors plus reset-mid-TLP and sequence-wrap runs.
module tb_lcrc_feed_sequencer;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic         clk = 1'b0;
    logic         rstN;
    logic [127:0] tlpData;
    logic         tlpValid, tlpLast, tlpReady, rbFull;
    logic [1:0]   lcrcCtrl;
    logic         lcrcStart, lcrcEnd, lcrcSkip;
    logic [127:0] lcrcData;
    logic [31:0]  lcrcIn;
    logic         lcrcVld;
    logic         done, tlpErr, busy;
    logic [11:0]  seqOut;
    logic [31:0]  crcOut;

    int           checks = 0;
    int           failures = 0;
    logic [11:0]  expSeq;
    int           engDelay = 0;
    int           engCnt = 0;
    logic [31:0]  engCrc;

    typedef struct {
        logic [127:0] beat0;
        logic [127:0] beat1;
        logic         two;
        logic         last1;
        int           gap;
        int           delay;
        int           hold;
        logic         rbLate;
        logic         expErr;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    lcrc_feed_sequencer dut (
        .clk          (clk),
        .rst_n        (rstN),
        .tlp_data_i   (tlpData),
        .tlp_valid_i  (tlpValid),
        .tlp_last_i   (tlpLast),
        .tlp_ready_o  (tlpReady),
        .rb_full_i    (rbFull),
        .lcrc_ctrl_o  (lcrcCtrl),
        .lcrc_start_o (lcrcStart),
        .lcrc_data_o  (lcrcData),
        .lcrc_end_o   (lcrcEnd),
        .lcrc_skip_o  (lcrcSkip),
        .lcrc_in_i    (lcrcIn),
        .lcrc_vld_i   (lcrcVld),
        .done_o       (done),
        .seq_o        (seqOut),
        .crc_o        (crcOut),
        .tlp_err_o    (tlpErr),
        .busy_o       (busy)
    );

    function automatic logic [31:0] crcFeed(input logic [31:0] c, input logic [127:0] d, input int n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < n; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] refCrc(input logic [11:0] s, input logic [127:0] b0,
                                           input logic [127:0] b1, input logic two);
        logic [31:0] r;
        r = crcFeed(32'hFFFF_FFFF, {116'b0, s}, 16);
        r = crcFeed(r, b0, 128);
        if (two) r = crcFeed(r, b1, 128);
        return ~r;
    endfunction

    // Engine model: follows start/ctrl, answers lcrc_vld after engDelay extra CRC cycles.
    always @(negedge clk) begin
        if (!rstN) begin
            engCrc  = 32'hFFFF_FFFF;
            engCnt  = 0;
            lcrcVld = 1'b0;
            lcrcIn  = '0;
        end else begin
            lcrcVld = 1'b0;
            if (lcrcStart) begin
                engCrc = crcFeed(32'hFFFF_FFFF, lcrcData, 16);
                engCnt = 0;
            end else if (lcrcCtrl == 2'b01 || lcrcCtrl == 2'b10) begin
                engCrc = crcFeed(engCrc, lcrcData, 128);
            end else if (lcrcCtrl == 2'b11) begin
                if (engCnt == engDelay) begin
                    lcrcVld = 1'b1;
                    lcrcIn  = ~engCrc;
                end
                engCnt++;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one TLP from IDLE through its done cycle; returns with the DUT in the done cycle.
    task automatic applyStimulus(input vec_t v);
        engDelay = v.delay;
        for (int h = 0; h < v.hold; h++) begin
            rbFull = 1'b1; tlpValid = 1'b1; tlpData = v.beat0; tlpLast = !v.two;
            #1;
            checkOutput("ready_rbfull", tlpReady, 0);
            nextCycle();
            checkOutput("idle_hold_busy", busy, 0);
        end
        rbFull = 1'b0; tlpValid = 1'b1; tlpData = v.beat0; tlpLast = !v.two;
        #1;
        checkOutput("ready_idle", tlpReady, 1);
        nextCycle();
        rbFull = v.rbLate;
        if (v.two) begin
            tlpValid = 1'b0;
            for (int g = 0; g < v.gap; g++) begin
                #1;
                checkOutput("collect_ready", tlpReady, 1);
                checkOutput("collect_busy", busy, 1);
                checkOutput("collect_start", lcrcStart, 0);
                nextCycle();
            end
            tlpValid = 1'b1; tlpData = v.beat1; tlpLast = v.last1;
            nextCycle();
        end
        tlpValid = 1'b0; tlpLast = 1'b0; tlpData = '0;
        #1;
        checkOutput("seq_start", lcrcStart, 1);
        checkOutput("seq_ctrl", lcrcCtrl, 0);
        checkOutput("seq_data", lcrcData, {116'b0, expSeq});
        checkOutput("seq_err", tlpErr, v.expErr);
        checkOutput("seq_ready", tlpReady, 0);
        checkOutput("seq_busy", busy, 1);
        checkOutput("seq_done", done, 0);
        nextCycle();
        checkOutput("b0_start", lcrcStart, 0);
        checkOutput("b0_ctrl", lcrcCtrl, 1);
        checkOutput("b0_data", lcrcData, v.beat0);
        checkOutput("b0_end", lcrcEnd, !v.two);
        checkOutput("b0_err", tlpErr, 0);
        nextCycle();
        if (v.two) begin
            checkOutput("b1_ctrl", lcrcCtrl, 2);
            checkOutput("b1_data", lcrcData, v.beat1);
            checkOutput("b1_end", lcrcEnd, 0);
            checkOutput("b1_skip", lcrcSkip, 0);
            nextCycle();
        end
        for (int d = 0; d <= v.delay; d++) begin
            checkOutput("crc_ctrl", lcrcCtrl, 3);
            checkOutput("crc_skip", lcrcSkip, !v.two);
            checkOutput("crc_data", lcrcData, 0);
            checkOutput("crc_done", done, 0);
            checkOutput("crc_ready", tlpReady, 0);
            nextCycle();
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("done_seq", seqOut, expSeq);
        checkOutput("done_crc", crcOut, refCrc(expSeq, v.beat0, v.beat1, v.two));
        checkOutput("done_busy", busy, 0);
        checkOutput("done_ctrl", lcrcCtrl, 0);
        checkOutput("done_ready", tlpReady, !v.rbLate);
        expSeq = expSeq + 12'd1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_ready"}, tlpReady, 0);
        checkOutput({tag, "_done"},  done, 0);
        checkOutput({tag, "_err"},   tlpErr, 0);
        checkOutput({tag, "_ctrl"},  lcrcCtrl, 0);
        checkOutput({tag, "_start"}, lcrcStart, 0);
        checkOutput({tag, "_data"},  lcrcData, 0);
        checkOutput({tag, "_end"},   lcrcEnd, 0);
        checkOutput({tag, "_skip"},  lcrcSkip, 0);
        checkOutput({tag, "_crc"},   crcOut, 32'hFFFF_FFFF);
        checkOutput({tag, "_seq"},   seqOut, 0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{128'h0123456789ABCDEF0123456789ABCDEF, 128'h0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        tbl[1] = '{128'hDEADBEEF_00112233_44556677_8899AABB, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C,
                   1'b1, 1'b1, 3, 2, 0, 1'b0, 1'b0};
        tbl[2] = '{128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 128'h00000001_00000002_00000003_00000004,
                   1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1};
        tbl[3] = '{128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, 128'h0, 1'b0, 1'b1, 0, 1, 3, 1'b1, 1'b0};
        tbl[4] = '{128'h13579BDF_2468ACE0_13579BDF_2468ACE0, 128'hFEDCBA98_76543210_FEDCBA98_76543210,
                   1'b1, 1'b1, 1, 0, 0, 1'b1, 1'b0};

        tlpData = '0; tlpValid = 1'b0; tlpLast = 1'b0; rbFull = 1'b0;
        rstN = 1'b1;
        #2 rstN = 1'b0;
        #1;
        checkResetOutputs("reset_init");
        @(posedge clk);
        #1 rstN = 1'b1;
        nextCycle();
        checkOutput("idle_ready_after_reset", tlpReady, 1);
        expSeq = 12'd0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i]);
        end

        // Reset asserted while beat1 is being fed to the engine.
        nextCycle();
        rbFull = 1'b0;
        tlpValid = 1'b1; tlpData = 128'h1111; tlpLast = 1'b0;
        nextCycle();
        tlpData = 128'h2222; tlpLast = 1'b1;
        nextCycle();
        tlpValid = 1'b0; tlpLast = 1'b0; tlpData = '0;
        nextCycle();
        nextCycle();
        checkOutput("b1_before_reset", lcrcCtrl, 2);
        rstN = 1'b0;
        #1;
        checkResetOutputs("reset_mid");
        repeat (3) begin
            nextCycle();
            checkOutput("reset_hold_done", done, 0);
        end
        rstN = 1'b1;
        expSeq = 12'd0;
        repeat (3) begin
            nextCycle();
            checkOutput("post_reset_no_done", done, 0);
            checkOutput("post_reset_idle", busy, 0);
        end
        applyStimulus(tbl[0]);

        // Back-to-back single-beat TLPs across the sequence-number wrap.
        rstN = 1'b0;
        #1;
        rstN = 1'b1;
        expSeq = 12'd0;
        nextCycle();
        for (int k = 0; k < 4097; k++) begin
            v = '{{$urandom, $urandom, $urandom, $urandom}, 128'h0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0};
            applyStimulus(v);
        end
        checkOutput("wrap_final_seq", seqOut, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
